// File: rtl/trap_ctrl_pkg.sv
// Shared constants for trap_ctrl: CSR addresses, instruction encodings,
// mstatus/mie bit positions, cause codes and FSM state encoding.
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int MIE_MSIE = 3;
  localparam int MIE_MTIE = 7;
  localparam int MIE_MEIE = 11;

  localparam int CAUSE_ECALL_M = 11;
  localparam int CAUSE_MSI     = 3;
  localparam int CAUSE_MTI     = 7;
  localparam int CAUSE_MEI     = 11;

  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_SAVE_EPC       = 3'd1,
    ST_SAVE_CAUSE     = 3'd2,
    ST_SAVE_STATUS    = 3'd3,
    ST_RESTORE_STATUS = 3'd4,
    ST_JUMP           = 3'd5
  } state_t;

endpackage

// File: rtl/trap_ctrl_irq_gateway.sv
// Per-source external interrupt gateway: synchroniser plus pending latch cleared by claim.
// TRAP_EDGE_EN selects rising-edge sticky pending; otherwise pending follows the synchronised level.
module trap_ctrl_irq_gateway (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic claim,
  output logic pending
);

`ifdef TRAP_EDGE_EN
  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;
  logic pending_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      prev_reg    <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      sync1_reg <= irq;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      // A new edge in the claim cycle must not be lost, so set beats clear.
      if (sync2_reg && !prev_reg) begin
        pending_reg <= 1'b1;
      end else if (claim) begin
        pending_reg <= 1'b0;
      end
    end
  end
`else
  logic sync1_reg;
  logic pending_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg   <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      sync1_reg <= irq;
      // Second synchroniser stage doubles as the pending bit; claim drops it for one cycle.
      pending_reg <= sync1_reg && !claim;
    end
  end
`endif

  assign pending = pending_reg;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: arbitrates ECALL/MRET/interrupts and sequences mepc/mcause/mstatus writes.
// Build option TRAP_EDGE_EN makes external pending bits edge-triggered and sticky.
module trap_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_EXT_IRQ    = 8,
  parameter int EXT_CAUSE_BASE = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [31:0]            inst_i,
  input  logic [ADDR_WIDTH-1:0]  inst_addr_i,
  input  logic                   inst_valid_i,
  input  logic [NUM_EXT_IRQ-1:0] ext_irq_i,
  input  logic                   timer_irq_i,
  input  logic                   soft_irq_i,
  input  logic [ADDR_WIDTH-1:0]  mtvec_i,
  input  logic [ADDR_WIDTH-1:0]  mepc_i,
  input  logic [ADDR_WIDTH-1:0]  mstatus_i,
  input  logic [ADDR_WIDTH-1:0]  mie_i,
  output logic                   csr_we_o,
  output logic [11:0]            csr_waddr_o,
  output logic [ADDR_WIDTH-1:0]  csr_wdata_o,
  output logic                   stall_o,
  output logic                   jump_en_o,
  output logic [ADDR_WIDTH-1:0]  jump_addr_o,
  output logic [NUM_EXT_IRQ-1:0] pending_o
);

  import trap_ctrl_pkg::*;

  state_t state_reg;
  state_t state_next;

  logic [NUM_EXT_IRQ-1:0] pending;
  logic [NUM_EXT_IRQ-1:0] claim;
  logic [NUM_EXT_IRQ-1:0] ext_first;
  logic [ADDR_WIDTH-1:0]  code_chain [NUM_EXT_IRQ+1];

  logic [ADDR_WIDTH-1:0] epc_reg;
  logic [ADDR_WIDTH-1:0] cause_reg;
  logic [ADDR_WIDTH-1:0] status_reg;
  logic [ADDR_WIDTH-1:0] target_reg;

  logic [ADDR_WIDTH-1:0] ext_code;
  logic [ADDR_WIDTH-1:0] code;
  logic [ADDR_WIDTH-1:0] cause_val;
  logic [ADDR_WIDTH-1:0] vec_base;
  logic [ADDR_WIDTH-1:0] trap_target;
  logic [ADDR_WIDTH-1:0] status_trap;
  logic [ADDR_WIDTH-1:0] status_mret;

  logic is_ecall;
  logic is_mret;
  logic irq_on;
  logic ext_hit;
  logic soft_hit;
  logic timer_hit;
  logic can_detect;
  logic take_irq;
  logic take_trap;
  logic take_mret;
  logic unused_mie;

  generate
    for (genvar gi = 0; gi < NUM_EXT_IRQ; gi++) begin : g_gw
      trap_ctrl_irq_gateway u_gw (
        .clk     (clk_i),
        .rst     (rst_i),
        .irq     (ext_irq_i[gi]),
        .claim   (claim[gi]),
        .pending (pending[gi])
      );
    end
  endgenerate

  assign pending_o = pending;

  // Priority chain: the lowest pending index ends up at the head.
  assign code_chain[NUM_EXT_IRQ] = '0;
  generate
    for (genvar gi = 0; gi < NUM_EXT_IRQ; gi++) begin : g_code
      assign code_chain[gi] = pending[gi] ? ADDR_WIDTH'(EXT_CAUSE_BASE + gi) : code_chain[gi+1];
    end
  endgenerate
  assign ext_code  = code_chain[0];
  assign ext_first = pending & (~pending + NUM_EXT_IRQ'(1));

  assign is_ecall   = (inst_i == INST_ECALL);
  assign is_mret    = (inst_i == INST_MRET);
  assign irq_on     = mstatus_i[MSTATUS_MIE];
  assign ext_hit    = irq_on & mie_i[MIE_MEIE] & (|pending);
  assign soft_hit   = irq_on & mie_i[MIE_MSIE] & soft_irq_i;
  assign timer_hit  = irq_on & mie_i[MIE_MTIE] & timer_irq_i;
  assign unused_mie = ^mie_i;

  // Reset gates detection so stall_o is low while rst_i is held.
  assign can_detect = (state_reg == ST_IDLE) & inst_valid_i & ~rst_i;
  assign take_irq   = can_detect & ~is_ecall & ~is_mret & (ext_hit | soft_hit | timer_hit);
  assign take_trap  = (can_detect & is_ecall) | take_irq;
  assign take_mret  = can_detect & ~is_ecall & is_mret;
  assign claim      = (take_irq & ext_hit) ? ext_first : '0;

  always_comb begin
    if (ext_hit) begin
      code = ext_code;
    end else if (soft_hit) begin
      code = ADDR_WIDTH'(CAUSE_MSI);
    end else begin
      code = ADDR_WIDTH'(CAUSE_MTI);
    end
  end

  assign cause_val   = is_ecall ? ADDR_WIDTH'(CAUSE_ECALL_M)
                                : (code | (ADDR_WIDTH'(1) << (ADDR_WIDTH - 1)));
  assign vec_base    = {mtvec_i[ADDR_WIDTH-1:2], 2'b00};
  assign trap_target = (!is_ecall && (mtvec_i[1:0] == MTVEC_VECTORED)) ? (vec_base + (code << 2))
                                                                       : vec_base;

  always_comb begin
    status_trap = mstatus_i;
    status_trap[MSTATUS_MPIE] = mstatus_i[MSTATUS_MIE];
    status_trap[MSTATUS_MIE]  = 1'b0;
    status_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    status_mret = mstatus_i;
    status_mret[MSTATUS_MIE]  = mstatus_i[MSTATUS_MPIE];
    status_mret[MSTATUS_MPIE] = 1'b1;
  end

  // Everything the sequence writes is frozen at detection; only the MRET target is taken later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      epc_reg    <= '0;
      cause_reg  <= '0;
      status_reg <= '0;
      target_reg <= '0;
    end else begin
      if (take_trap) begin
        epc_reg    <= inst_addr_i;
        cause_reg  <= cause_val;
        status_reg <= status_trap;
        target_reg <= trap_target;
      end else if (take_mret) begin
        status_reg <= status_mret;
      end
      if (state_reg == ST_RESTORE_STATUS) begin
        target_reg <= mepc_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    stall_o     = 1'b0;
    csr_we_o    = 1'b0;
    csr_waddr_o = '0;
    csr_wdata_o = '0;
    jump_en_o   = 1'b0;
    jump_addr_o = '0;
    case (state_reg)
      ST_IDLE: begin
        if (take_trap) begin
          state_next = ST_SAVE_EPC;
          stall_o    = 1'b1;
        end else if (take_mret) begin
          state_next = ST_RESTORE_STATUS;
          stall_o    = 1'b1;
        end
      end
      ST_SAVE_EPC: begin
        state_next  = ST_SAVE_CAUSE;
        stall_o     = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MEPC;
        csr_wdata_o = epc_reg;
      end
      ST_SAVE_CAUSE: begin
        state_next  = ST_SAVE_STATUS;
        stall_o     = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MCAUSE;
        csr_wdata_o = cause_reg;
      end
      ST_SAVE_STATUS: begin
        state_next  = ST_JUMP;
        stall_o     = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = status_reg;
      end
      ST_RESTORE_STATUS: begin
        state_next  = ST_JUMP;
        stall_o     = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = status_reg;
      end
      ST_JUMP: begin
        state_next  = ST_IDLE;
        stall_o     = 1'b1;
        jump_en_o   = 1'b1;
        jump_addr_o = target_reg;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed testbench for trap_ctrl: each task drives one scenario and checks hand-computed values.
module tb_trap_ctrl;

  localparam int AW = 32;
  localparam int NE = 8;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] MRET  = 32'h3020_0073;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [31:0]   inst_i;
  logic [AW-1:0] inst_addr_i;
  logic          inst_valid_i;
  logic [NE-1:0] ext_irq_i;
  logic          timer_irq_i;
  logic          soft_irq_i;
  logic [AW-1:0] mtvec_i, mepc_i, mstatus_i, mie_i;
  logic          csr_we_o;
  logic [11:0]   csr_waddr_o;
  logic [AW-1:0] csr_wdata_o;
  logic          stall_o;
  logic          jump_en_o;
  logic [AW-1:0] jump_addr_o;
  logic [NE-1:0] pending_o;

  int total = 0;
  int bad = 0;

  int            stall_cnt, jcnt, jump_c;
  logic [35:0]   wseq;
  logic [AW-1:0] epc_w, cause_w, status_w, jump_a;
  logic [NE-1:0] p1;

  trap_ctrl #(.ADDR_WIDTH(AW), .NUM_EXT_IRQ(NE), .EXT_CAUSE_BASE(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .inst_valid_i(inst_valid_i), .ext_irq_i(ext_irq_i), .timer_irq_i(timer_irq_i),
    .soft_irq_i(soft_irq_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i), .mstatus_i(mstatus_i),
    .mie_i(mie_i), .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .stall_o(stall_o), .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o), .pending_o(pending_o)
  );

  always #5 clk = ~clk;

  // Records an 8-cycle window starting at the detect cycle; the instruction becomes a bubble after it.
  task automatic run_seq();
    stall_cnt = 0; jcnt = 0; jump_c = -1; wseq = '0;
    epc_w = '0; cause_w = '0; status_w = '0; jump_a = '0; p1 = '0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (stall_o) stall_cnt++;
      if (csr_we_o) begin
        wseq = {wseq[23:0], csr_waddr_o};
        if (csr_waddr_o == 12'h341) epc_w = csr_wdata_o;
        if (csr_waddr_o == 12'h342) cause_w = csr_wdata_o;
        if (csr_waddr_o == 12'h300) status_w = csr_wdata_o;
      end
      if (jump_en_o) begin
        jcnt++;
        if (jump_c < 0) begin jump_c = c; jump_a = jump_addr_o; end
      end
      if (c == 1) p1 = pending_o;
      @(negedge clk);
      if (c == 0) inst_valid_i = 1'b0;
    end
  endtask

  task automatic issue(input logic [31:0] inst, input logic [AW-1:0] pc);
    @(negedge clk);
    inst_i = inst; inst_addr_i = pc; inst_valid_i = 1'b1;
    run_seq();
    $display("txn inst=%h pc=%h: writes=%h epc=%h cause=%h status=%h jump=%h at +%0d stall=%0d",
             inst, pc, wseq, epc_w, cause_w, status_w, jump_a, jump_c, stall_cnt);
  endtask

  task automatic test_reset();
    inst_i = ECALL; inst_addr_i = 32'h10; inst_valid_i = 1'b1; ext_irq_i = '1;
    repeat (2) @(negedge clk);
    #1;
    total++; if ({csr_we_o, csr_waddr_o, csr_wdata_o, stall_o, jump_en_o, jump_addr_o} !== '0) begin
      bad++; $display("FAIL reset_outputs act we=%b addr=%h data=%h stall=%b jen=%b jaddr=%h req all 0",
                      csr_we_o, csr_waddr_o, csr_wdata_o, stall_o, jump_en_o, jump_addr_o); end
    total++; if (pending_o !== '0) begin bad++; $display("FAIL reset_pending act=%h req=00", pending_o); end
    @(negedge clk);
    rst_i = 1'b0; inst_valid_i = 1'b0; ext_irq_i = '0;
    repeat (3) @(negedge clk);
    $display("txn reset released");
  endtask

  task automatic test_ecall();
    mtvec_i = 32'h800; mstatus_i = 32'h8; mie_i = '0;
    issue(ECALL, 32'h100);
    total++; if (wseq !== {12'h341, 12'h342, 12'h300}) begin bad++; $display("FAIL ecall_order act=%h req=341342300", wseq); end
    total++; if (epc_w !== 32'h100) begin bad++; $display("FAIL ecall_mepc act=%h req=00000100", epc_w); end
    total++; if (cause_w !== 32'd11) begin bad++; $display("FAIL ecall_mcause act=%h req=0000000b", cause_w); end
    total++; if (status_w !== 32'h1880) begin bad++; $display("FAIL ecall_mstatus act=%h req=00001880", status_w); end
    total++; if (jump_c !== 4 || jump_a !== 32'h800) begin bad++; $display("FAIL ecall_jump act=%h@%0d req=00000800@4", jump_a, jump_c); end
    total++; if (stall_cnt !== 5 || jcnt !== 1) begin bad++; $display("FAIL ecall_stall act=%0d/%0d req=5/1", stall_cnt, jcnt); end
  endtask

  task automatic test_mret();
    mstatus_i = 32'h80; mepc_i = 32'h104;
    issue(MRET, 32'h50);
    total++; if (wseq !== {24'h0, 12'h300} || status_w !== 32'h88) begin
      bad++; $display("FAIL mret_status act=%h/%h req=300/00000088", wseq, status_w); end
    total++; if (jump_c !== 2 || jump_a !== 32'h104) begin bad++; $display("FAIL mret_jump act=%h@%0d req=00000104@2", jump_a, jump_c); end
    total++; if (stall_cnt !== 3) begin bad++; $display("FAIL mret_stall act=%0d req=3", stall_cnt); end
  endtask

  task automatic test_ext_vectored();
    @(negedge clk);
    mtvec_i = 32'h801; mstatus_i = 32'h8; mie_i = 32'h800; ext_irq_i = 8'h04; inst_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    total++; if (pending_o !== 8'h04) begin bad++; $display("FAIL ext_pending act=%h req=04", pending_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL ext_novalid_stall act=%b req=0", stall_o); end
    issue(NOP, 32'h120);
    total++; if (cause_w !== 32'h8000_0012) begin bad++; $display("FAIL ext_mcause act=%h req=80000012", cause_w); end
    total++; if (jump_a !== 32'h848 || jump_c !== 4) begin bad++; $display("FAIL ext_jump act=%h@%0d req=00000848@4", jump_a, jump_c); end
    total++; if (epc_w !== 32'h120) begin bad++; $display("FAIL ext_mepc act=%h req=00000120", epc_w); end
    total++; if (p1 !== 8'h00) begin bad++; $display("FAIL ext_claim act=%h req=00", p1); end
    ext_irq_i = '0; mstatus_i = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_ext_order();
    int cnt;
    mtvec_i = 32'h801; mstatus_i = 32'h8; mie_i = 32'h888; ext_irq_i = 8'h22; timer_irq_i = 1'b1;
    repeat (4) @(negedge clk);
    issue(NOP, 32'h300);
    total++; if (cause_w !== 32'h8000_0011 || jump_a !== 32'h844) begin
      bad++; $display("FAIL order_first act=%h/%h req=80000011/00000844", cause_w, jump_a); end
    total++; if (p1 !== 8'h20) begin bad++; $display("FAIL order_pending act=%h req=20", p1); end
    ext_irq_i[1] = 1'b0; mstatus_i = 32'h1880; inst_i = NOP; inst_valid_i = 1'b1; cnt = 0;
    repeat (4) begin @(negedge clk); #1; if (stall_o) cnt++; end
    total++; if (cnt !== 0) begin bad++; $display("FAIL order_masked act=%0d req=0", cnt); end
    mepc_i = 32'h300;
    issue(MRET, 32'h844);
    total++; if (status_w !== 32'h1888 || jump_a !== 32'h300) begin
      bad++; $display("FAIL order_mret act=%h/%h req=00001888/00000300", status_w, jump_a); end
    mstatus_i = 32'h1888;
    issue(NOP, 32'h300);
    total++; if (cause_w !== 32'h8000_0015 || jump_a !== 32'h854) begin
      bad++; $display("FAIL order_second act=%h/%h req=80000015/00000854", cause_w, jump_a); end
    ext_irq_i[5] = 1'b0; mstatus_i = 32'h1880;
    repeat (3) @(negedge clk);
    issue(MRET, 32'h854);
    mstatus_i = 32'h1888;
    issue(NOP, 32'h300);
    total++; if (cause_w !== 32'h8000_0007 || jump_a !== 32'h81c) begin
      bad++; $display("FAIL order_timer act=%h/%h req=80000007/0000081c", cause_w, jump_a); end
    timer_irq_i = 1'b0; mstatus_i = '0;
  endtask

  task automatic test_ecall_timer();
    int cnt;
    mtvec_i = 32'h801; mstatus_i = 32'h8; mie_i = 32'h80; timer_irq_i = 1'b1;
    issue(ECALL, 32'h400);
    total++; if (cause_w !== 32'd11 || jump_a !== 32'h800 || status_w !== 32'h1880) begin
      bad++; $display("FAIL ecall_wins act=%h/%h/%h req=0000000b/00000800/00001880", cause_w, jump_a, status_w); end
    mstatus_i = 32'h1880; mepc_i = 32'h404;
    issue(MRET, 32'h800);
    total++; if (jump_a !== 32'h404 || status_w !== 32'h1888) begin
      bad++; $display("FAIL ecall_mret act=%h/%h req=00000404/00001888", jump_a, status_w); end
    mstatus_i = 32'h1888; inst_valid_i = 1'b0; cnt = 0;
    repeat (3) begin @(negedge clk); #1; if (stall_o || csr_we_o) cnt++; end
    total++; if (cnt !== 0) begin bad++; $display("FAIL bubble_ignored act=%0d req=0", cnt); end
    issue(NOP, 32'h404);
    total++; if (cause_w !== 32'h8000_0007 || jump_a !== 32'h81c || epc_w !== 32'h404) begin
      bad++; $display("FAIL timer_after act=%h/%h/%h req=80000007/0000081c/00000404", cause_w, jump_a, epc_w); end
    timer_irq_i = 1'b0; mstatus_i = '0;
  endtask

  task automatic test_wrap();
    mtvec_i = 32'hFFFF_FFFD; mstatus_i = 32'h8; mie_i = 32'h800; ext_irq_i = 8'h80;
    repeat (4) @(negedge clk);
    issue(NOP, 32'h600);
    total++; if (cause_w !== 32'h8000_0017 || jump_a !== 32'h58) begin
      bad++; $display("FAIL wrap_target act=%h/%h req=80000017/00000058", cause_w, jump_a); end
    ext_irq_i = '0; mstatus_i = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_soft_gating();
    mtvec_i = 32'h802; mstatus_i = 32'h8; mie_i = 32'h8; soft_irq_i = 1'b1; ext_irq_i = 8'h01;
    repeat (4) @(negedge clk);
    issue(NOP, 32'h500);
    total++; if (cause_w !== 32'h8000_0003 || jump_a !== 32'h800) begin
      bad++; $display("FAIL soft_mode2 act=%h/%h req=80000003/00000800", cause_w, jump_a); end
    total++; if (p1 !== 8'h01) begin bad++; $display("FAIL masked_ext_kept act=%h req=01", p1); end
    soft_irq_i = 1'b0; ext_irq_i = '0; mstatus_i = '0;
  endtask

  task automatic test_reset_mid();
    int cnt;
    mie_i = '0; mstatus_i = '0; mtvec_i = 32'h800; ext_irq_i = 8'h08;
    repeat (4) @(negedge clk);
    #1;
    total++; if (pending_o[3] !== 1'b1) begin bad++; $display("FAIL rmid_pending act=%h req=bit3 set", pending_o); end
    @(negedge clk);
    inst_i = ECALL; inst_addr_i = 32'h700; inst_valid_i = 1'b1;
    #1;
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL rmid_detect act=%b req=1", stall_o); end
    @(negedge clk);
    inst_valid_i = 1'b0;
    @(negedge clk);
    #1;
    total++; if ({csr_we_o, csr_waddr_o} !== {1'b1, 12'h342}) begin
      bad++; $display("FAIL rmid_cause_state act=%b/%h req=1/342", csr_we_o, csr_waddr_o); end
    rst_i = 1'b1;
    #1;
    total++; if ({csr_we_o, csr_waddr_o, csr_wdata_o, stall_o, jump_en_o, jump_addr_o} !== '0) begin
      bad++; $display("FAIL rmid_outputs act we=%b addr=%h data=%h stall=%b jen=%b jaddr=%h req all 0",
                      csr_we_o, csr_waddr_o, csr_wdata_o, stall_o, jump_en_o, jump_addr_o); end
    total++; if (pending_o !== '0) begin bad++; $display("FAIL rmid_pending_clr act=%h req=00", pending_o); end
    repeat (2) @(negedge clk);
    rst_i = 1'b0; cnt = 0;
    repeat (6) begin @(negedge clk); #1; if (csr_we_o || stall_o) cnt++; end
    total++; if (cnt !== 0) begin bad++; $display("FAIL rmid_no_write act=%0d req=0", cnt); end
    ext_irq_i = '0;
    $display("txn reset during SAVE_CAUSE");
  endtask

  initial begin
    rst_i = 1'b1; inst_i = NOP; inst_addr_i = '0; inst_valid_i = 1'b0;
    ext_irq_i = '0; timer_irq_i = 1'b0; soft_irq_i = 1'b0;
    mtvec_i = '0; mepc_i = '0; mstatus_i = '0; mie_i = '0;
    test_reset();
    test_ecall();
    test_mret();
    test_ext_vectored();
    test_ext_order();
    test_ecall_timer();
    test_wrap();
    test_soft_gating();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Parametrised machine-mode trap controller that replaces the single-cycle combinational interrupt path.
- Latches N external interrupt sources plus timer and software interrupts, and arbitrates them against ECALL/MRET.
- Sequences the CSR updates (mepc, mcause, mstatus) through a multi-cycle FSM.
- Issues one redirect (jump + flush) to the fetch stage.
- Sits beside the csr_reg file and the execute stage; it owns all trap-entry and trap-return CSR writes.

Parameters:
- ADDR_WIDTH, 32, width of addresses and CSR data.
- NUM_EXT_IRQ, 8, number of external interrupt sources (1..16).
- EXT_CAUSE_BASE, 16, mcause code assigned to external source 0; source k uses EXT_CAUSE_BASE+k.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- inst_i  in  32  instruction in execute
- inst_addr_i  in  ADDR_WIDTH  PC of inst_i
- inst_valid_i  in  1  inst_i is real (not a bubble)
- ext_irq_i  in  NUM_EXT_IRQ  external interrupt lines
- timer_irq_i  in  1  machine timer interrupt
- soft_irq_i  in  1  machine software interrupt
- mtvec_i, mepc_i, mstatus_i, mie_i  in  ADDR_WIDTH each  current CSR values
- csr_we_o  out  1  CSR write strobe
- csr_waddr_o  out  12  CSR address
- csr_wdata_o  out  ADDR_WIDTH  CSR write data
- stall_o  out  1  hold pipeline
- jump_en_o  out  1  one-cycle redirect strobe (also the flush strobe)
- jump_addr_o  out  ADDR_WIDTH  redirect target
- pending_o  out  NUM_EXT_IRQ  latched external pending bits (debug)

Behaviour:
- Reset: every output is 0, FSM is IDLE, pending and capture registers are cleared. Reset mid-sequence aborts it immediately; no partial CSR write completes after reset.
- FSM states: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, RESTORE_STATUS, JUMP. Each non-IDLE state lasts exactly one cycle.
- Detection happens in IDLE when inst_valid_i=1. Priority, highest first:
  - ECALL
  - MRET
  - external (lowest index wins)
  - software
  - timer
- Gating: interrupts require mstatus_i[3]=1 plus their enable bit (mie_i[11] for any external, mie_i[3] software, mie_i[7] timer). ECALL and MRET are never masked.
- Trap path: IDLE→SAVE_EPC→SAVE_CAUSE→SAVE_STATUS→JUMP→IDLE.
  - Detect cycle registers cause and target.
  - SAVE_EPC writes 0x341 ← inst_addr_i (captured).
  - SAVE_CAUSE writes 0x342 ← cause. ECALL = 11; interrupts set bit ADDR_WIDTH-1, with code 11 (used only when NUM_EXT_IRQ=0), 3, 7, or EXT_CAUSE_BASE+k.
  - SAVE_STATUS writes 0x300 ← mstatus with MPIE(bit7) ← MIE(bit3), MIE ← 0, MPP(12:11) ← 2'b11.
- MRET path: IDLE→RESTORE_STATUS→JUMP→IDLE.
  - RESTORE_STATUS writes 0x300 with MIE ← MPIE, MPIE ← 1.
  - Target is mepc_i sampled in RESTORE_STATUS.
- Timing:
  - stall_o is high from the detect cycle through JUMP inclusive.
  - jump_en_o is high only in JUMP.
  - Redirect latency from detect: trap 4 cycles, MRET 2 cycles.
- Target: if mtvec_i[1:0]=1 and the trap is an interrupt, target = {mtvec_i[ADDR_WIDTH-1:2],2'b00} + 4×code. Otherwise (exceptions, or mode 0/2/3) target = {mtvec_i[ADDR_WIDTH-1:2],2'b00}. The sum wraps modulo 2^ADDR_WIDTH.
- Pending: the claimed external bit clears on entry to SAVE_EPC. If a new set event occurs in the same cycle, set wins. Events arriving while the FSM is busy stay pending and are arbitrated on return to IDLE.
- inst_valid_i=0 in IDLE: nothing is accepted and the FSM stays IDLE.
- Input changes during a sequence are ignored apart from the pending latches.

Optional Feature:
- TRAP_EDGE_EN defined: each ext_irq_i bit passes through a 2-flop synchroniser plus a rising-edge detector that sets a sticky pending bit. The bit is cleared only by claim.
- TRAP_EDGE_EN undefined: level-sensitive. pending = synchronised ext_irq_i, with no latching; a source deasserting before detection is lost.

Decomposition:
- defines.v: CSR addresses (MEPC 0x341, MCAUSE 0x342, MSTATUS 0x300), ECALL/MRET encodings, state encodings, mstatus bit positions, cause codes.
- Sub-module irq_gateway: per-source synchroniser, edge detect, and pending latch with claim clear. Instantiated NUM_EXT_IRQ times via generate.

Test Plan:
- ECALL at PC 0x100, mtvec=0x800 (mode 0), mstatus=0x8 → writes mepc=0x100, mcause=11, mstatus=0x1880; jump_en_o to 0x800 at detect+4; stall_o high 5 cycles.
- mtvec=0x801, MIE=1, mie[11]=1, pulse ext_irq_i[2] → mcause=0x80000012, jump to 0x800+4×18=0x848.
- ext_irq_i[5] and ext_irq_i[1] together with timer_irq_i → source 1 serviced first; 5 and timer remain pending and are serviced after MRET restores MIE.
- MRET with mstatus=0x80, mepc=0x104 → mstatus write 0x88, jump to 0x104 at detect+2.
- ECALL coincident with an enabled timer interrupt → ECALL wins; the timer is serviced after a later MRET.
- rst_i asserted during SAVE_CAUSE → all outputs 0 the same cycle, no mstatus write, pending_o=0.
